postta_conv: RTL and testbench

// - Winograd F(2x2,3x3) output (inverse) transform Y = A^T*M*A; counterpart of the B^T*d*B input transform.
// - Consumes a 4x4 element-wise-product tile one row per beat; emits a rounded, saturated 2x2 output tile.
// - Sits between the EWMM accumulator and the output-feature-map writer.
// - A^T = {{1,1,1,0},{0,1,-1,-1}}.

---
 rtl/preta_pkg.sv | 27 ++
 rtl/postta_round_sat.sv | 51 +++++
 rtl/postta_conv.sv | 183 ++++++++++++++++++
 tb/tb_postta_conv.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preta_pkg.sv
// -----------------------------------------------------------------------------
// preta_pkg
// Shared definitions for the Winograd F(2x2,3x3) transform blocks.
//   ACC_W_DEF / OUT_W_DEF : default element widths (accumulator / output pixel)
//   AT                    : output-transform matrix A^T, rows x taps
//   int_w()               : internal width that makes a 4x4 -> 2x2 reduction
//                           wrap-free (worst case |Y| <= 9 * 2^(ACC_W-1))
//   row_t / tile_t        : packed row / tile types at the default widths
// -----------------------------------------------------------------------------
package preta_pkg;

  localparam int ACC_W_DEF = 22;
  localparam int OUT_W_DEF = 16;

  // A^T = {{1,1,1,0},{0,1,-1,-1}}
  localparam int AT [0:1][0:3] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  // Four guard bits: nine terms of magnitude <= 2^(ACC_W-1) stay well inside
  // 2^(ACC_W+3), so no intermediate sum can wrap.
  function automatic int int_w(input int acc_w);
    return acc_w + 4;
  endfunction

  typedef logic [0:3][ACC_W_DEF-1:0]      row_t;
  typedef logic [0:1][0:1][OUT_W_DEF-1:0] tile_t;

endpackage

// File: rtl/postta_round_sat.sv
// -----------------------------------------------------------------------------
// postta_round_sat
// Requantises one signed transform result: round-half-up by SHIFT bits, then
// saturate to the signed OUT_W range.
//   i_val : signed IN_W input (transform result)
//   o_val : signed OUT_W output (rounded, clipped)
//   o_sat : 1 when the value was clipped to the output range
// -----------------------------------------------------------------------------
module postta_round_sat
  import preta_pkg::*;
#(
  parameter int IN_W  = 26,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_sat
);

  // Rounding constant 2^(SHIFT-1); the inner ternary keeps the shift amount
  // non-negative when SHIFT is 0.
  localparam logic signed [IN_W:0] RND =
    (SHIFT > 0) ? ((IN_W + 1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

  // Output range limits sign-extended to the working width.
  localparam logic signed [IN_W:0] MAX_V =
    {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V =
    {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [IN_W:0] w_sum;
  logic signed [IN_W:0] w_sh;

  // One extra bit so adding the rounding constant can never overflow.
  assign w_sum = {i_val[IN_W-1], i_val} + RND;
  assign w_sh  = w_sum >>> SHIFT;

  always_comb begin
    o_sat = 1'b0;
    o_val = w_sh[OUT_W-1:0];
    if (w_sh > MAX_V) begin
      o_val = MAX_V[OUT_W-1:0];
      o_sat = 1'b1;
    end else if (w_sh < MIN_V) begin
      o_val = MIN_V[OUT_W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/postta_conv.sv
// -----------------------------------------------------------------------------
// postta_conv
// Winograd F(2x2,3x3) output transform Y = A^T * M * A. Takes a 4x4
// element-wise-product tile one row per beat and emits a rounded, saturated
// 2x2 output tile.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort of the partial tile (row counter -> 0);
//                a pending output tile is unaffected
//   in_valid / in_ready : row beat handshake
//   row_in     : signed row M[r][0..3]; r comes from the internal counter
//   out_valid / out_ready : output tile handshake
//   out_tile   : signed Y[0..1][0..1], held while out_valid && !out_ready
//   sat_pulse  : one-cycle flag, the tile just loaded had a clipped element
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// valid, once raised, holds with stable data until that transfer; ready may
// depend combinationally on the partner's valid/ready (out_ready -> in_ready).
// -----------------------------------------------------------------------------
module postta_conv
  import preta_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [0:3][ACC_W-1:0]        row_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:1][0:1][OUT_W-1:0]   out_tile,
  output logic                         sat_pulse
);

  localparam int INT_W = int_w(ACC_W);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                     r_row_cnt;
  logic signed [INT_W-1:0]        r_acc0 [0:1];   // running Y[0][c]
  logic signed [INT_W-1:0]        r_acc1 [0:1];   // running Y[1][c]
  logic                           r_out_valid;
  logic [0:1][0:1][OUT_W-1:0]     r_out_tile;
  logic                           r_sat_pulse;

  // ---------------------------------------------------------------------------
  // Datapath wires
  // ---------------------------------------------------------------------------
  logic signed [INT_W-1:0]        w_m  [0:3];      // sign-extended row
  logic signed [INT_W-1:0]        w_p  [0:1];      // (M*A)[r][c]
  logic signed [INT_W-1:0]        w_y  [0:1][0:1]; // final Y, valid on row 3
  logic signed [OUT_W-1:0]        w_rs [0:1][0:1]; // rounded / saturated Y
  logic [3:0]                     w_sat;
  logic                           w_accept;
  logic                           w_last;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Rows 0-2 never touch the output register, so they are always taken;
  // only the tile-completing row waits for the output slot to free up.
  assign in_ready = (r_row_cnt != 2'd3) || !r_out_valid || out_ready;

  // clear wins over a same-cycle beat: the beat is dropped.
  assign w_accept = in_valid && in_ready && !clear;
  assign w_last   = w_accept && (r_row_cnt == 2'd3);

  // ---------------------------------------------------------------------------
  // Row transform: p_c = sum_j AT[c][j] * M[r][j]
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_m[j] = {{(INT_W - ACC_W){row_in[j][ACC_W-1]}}, row_in[j]};
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_p[c] = '0;
      for (int j = 0; j < 4; j++) begin
        if (AT[c][j] > 0) begin
          w_p[c] = w_p[c] + w_m[j];
        end else if (AT[c][j] < 0) begin
          w_p[c] = w_p[c] - w_m[j];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final Y including the row-3 term. AT[0][3] = 0, so row 0 of Y is already
  // complete in r_acc0; row 1 still needs -p for row 3.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < 2; c++) begin : g_final
    assign w_y[0][c] = r_acc0[c];
    assign w_y[1][c] = r_acc1[c] - w_p[c];
  end

  for (genvar i = 0; i < 2; i++) begin : g_rs_row
    for (genvar k = 0; k < 2; k++) begin : g_rs_col
      postta_round_sat #(
        .IN_W  (INT_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
      ) u_round_sat (
        .i_val (w_y[i][k]),
        .o_val (w_rs[i][k]),
        .o_sat (w_sat[i*2+k])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Row counter and accumulators. Row 0 overwrites, so consecutive tiles need
  // no explicit accumulator clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt <= 2'd0;
      for (int c = 0; c < 2; c++) begin
        r_acc0[c] <= '0;
        r_acc1[c] <= '0;
      end
    end else if (clear) begin
      r_row_cnt <= 2'd0;
    end else if (w_accept) begin
      r_row_cnt <= r_row_cnt + 2'd1;
      for (int c = 0; c < 2; c++) begin
        case (r_row_cnt)
          2'd0: begin
            r_acc0[c] <= w_p[c];
            r_acc1[c] <= '0;
          end
          2'd1: begin
            r_acc0[c] <= r_acc0[c] + w_p[c];
            r_acc1[c] <= w_p[c];
          end
          2'd2: begin
            r_acc0[c] <= r_acc0[c] + w_p[c];
            r_acc1[c] <= r_acc1[c] - w_p[c];
          end
          default: begin
            r_acc1[c] <= r_acc1[c] - w_p[c];
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. A load in the same cycle as a drain keeps out_valid high
  // and replaces the tile.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_tile  <= '0;
      r_sat_pulse <= 1'b0;
    end else begin
      r_sat_pulse <= 1'b0;
      if (w_last) begin
        r_out_valid <= 1'b1;
        r_sat_pulse <= |w_sat;
        for (int i = 0; i < 2; i++) begin
          for (int k = 0; k < 2; k++) begin
            r_out_tile[i][k] <= w_rs[i][k];
          end
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_tile  = r_out_tile;
  assign sat_pulse = r_sat_pulse;

endmodule

// File: tb/tb_postta_conv.sv
// -----------------------------------------------------------------------------
// tb_postta_conv
// Two instances (SHIFT=0 and SHIFT=2) share one stimulus stream. Expected
// tiles come from a direct A^T*M*A matrix model with round/saturate and are
// queued when the completing row is accepted; a negedge monitor pops them on
// each output transfer and checks sat_pulse every cycle.
// -----------------------------------------------------------------------------
module tb_postta_conv;
  import preta_pkg::*;

  localparam int ACC_W = 22;
  localparam int OUT_W = 16;

  localparam logic [63:0] ONES_EXP = {16'h0009, 16'hfffd, 16'hfffd, 16'h0001};

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic  clk = 1'b0;
  logic  rst_n;
  always #5 clk = ~clk;

  logic  clear;
  logic  in_valid;
  logic  out_ready;
  row_t  row_in;
  logic  in_ready_0, in_ready_2;
  logic  out_valid_0, out_valid_2;
  logic  sat_0, sat_2;
  tile_t tile_0, tile_2;

  postta_conv #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0)) u_dut_s0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready_0),
    .row_in    (row_in),
    .out_valid (out_valid_0),
    .out_ready (out_ready),
    .out_tile  (tile_0),
    .sat_pulse (sat_0)
  );

  postta_conv #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(2)) u_dut_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready_2),
    .row_in    (row_in),
    .out_valid (out_valid_2),
    .out_ready (out_ready),
    .out_tile  (tile_2),
    .sat_pulse (sat_2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [63:0] exp0_q[$];
  logic [63:0] exp2_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m [0:3][0:3];
  int          stall_cnt;
  logic        load_flag;
  logic        load_sat0, load_sat2;
  int          at_tb [0:1][0:3] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: Y[i][k] = sum_r sum_j AT[i][r] * M[r][j] * AT[k][j]
  function automatic tile_t model(input int s, output logic sat);
    tile_t  t;
    longint y, hi, lo;
    hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo  = -(longint'(1) <<< (OUT_W - 1));
    sat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        y = 0;
        for (int r = 0; r < 4; r++) begin
          for (int j = 0; j < 4; j++) begin
            y += longint'(at_tb[i][r] * at_tb[k][j]) * longint'(m[r][j]);
          end
        end
        if (s > 0) y += longint'(1) <<< (s - 1);
        y = y >>> s;
        if (y > hi) begin
          y = hi; sat = 1'b1;
        end else if (y < lo) begin
          y = lo; sat = 1'b1;
        end
        t[i][k] = y[OUT_W-1:0];
      end
    end
    return t;
  endfunction

  function automatic row_t pack_row(input int r);
    row_t rw;
    for (int j = 0; j < 4; j++) rw[j] = m[r][j][ACC_W-1:0];
    return rw;
  endfunction

  task automatic set_all(input int v);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) m[r][j] = v;
  endtask

  task automatic rand_tile();
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        m[r][j] = int'($urandom_range(0, 4194303)) - 2097152;
  endtask

  // Called when the completing row has just been accepted.
  task automatic push_expected();
    tile_t t0, t2;
    logic  s0, s2;
    t0 = model(0, s0);
    t2 = model(2, s2);
    exp0_q.push_back(t0);
    exp2_q.push_back(t2);
    load_flag = 1'b1;
    load_sat0 = s0;
    load_sat2 = s2;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: each call starts and ends 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic send_row(input int r);
    int cyc;
    in_valid = 1'b1;
    row_in   = pack_row(r);
    @(negedge clk);
    cyc = 0;
    while (!(in_ready_0 && in_ready_2) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    stall_cnt += cyc;
    check("in_ready_wait", {62'd0, in_ready_0, in_ready_2}, 64'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (r == 3) push_expected();
  endtask

  task automatic send_tile();
    for (int r = 0; r < 4; r++) send_row(r);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: sat_pulse every cycle, tile on each output transfer
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("sat_pulse_s0", {63'd0, sat_0}, {63'd0, load_flag ? load_sat0 : 1'b0});
      check("sat_pulse_s2", {63'd0, sat_2}, {63'd0, load_flag ? load_sat2 : 1'b0});
      load_flag = 1'b0;
      if (out_valid_0 && out_ready) begin
        if (exp0_q.size() == 0) begin
          n_checks++; n_errors++;
          $error("FAIL unexpected_tile_s0 observed=%h expected=none", tile_0);
        end else begin
          check("tile_s0", tile_0, exp0_q.pop_front());
        end
      end
      if (out_valid_2 && out_ready) begin
        if (exp2_q.size() == 0) begin
          n_checks++; n_errors++;
          $error("FAIL unexpected_tile_s2 observed=%h expected=none", tile_2);
        end else begin
          check("tile_s2", tile_2, exp2_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int waited;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    row_in    = '0;
    load_flag = 1'b0;
    load_sat0 = 1'b0;
    load_sat2 = 1'b0;
    stall_cnt = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", {62'd0, out_valid_0, out_valid_2}, 64'd0);
    check("rst_tile_s0", tile_0, 64'd0);
    check("rst_tile_s2", tile_2, 64'd0);
    check("rst_sat", {62'd0, sat_0, sat_2}, 64'd0);
    check("rst_in_ready", {62'd0, in_ready_0, in_ready_2}, 64'd3);
    #2 rst_n = 1'b1;
    idle(2);

    // All-ones tile, latency of exactly one clock after the 4th beat
    set_all(1);
    send_row(0); send_row(1); send_row(2);
    check("ones_valid_before", {63'd0, out_valid_0}, 64'd0);
    send_row(3);
    check("ones_valid_after", {63'd0, out_valid_0}, 64'd1);
    check("ones_tile_s0", tile_0, ONES_EXP);
    idle(2);

    // Single centre tap: every Y = 4, >>2 -> 1
    set_all(0); m[1][1] = 4;
    send_tile();
    check("centre_tile_s2", tile_2, {16'd1, 16'd1, 16'd1, 16'd1});
    idle(2);

    // Rounding on Y00 only
    set_all(0); m[0][0] = 6;
    send_tile();
    check("round_pos_s2", tile_2, {16'd2, 48'd0});
    idle(1);
    set_all(0); m[0][0] = -6;
    send_tile();
    check("round_neg_s2", tile_2, {16'hffff, 48'd0});
    idle(2);

    // Saturation both ways
    set_all(0);
    for (int r = 0; r < 3; r++) for (int j = 0; j < 3; j++) m[r][j] = 1 << 20;
    send_tile();
    check("sat_pos_s0", tile_0, {16'h7fff, 48'd0});
    idle(2);
    for (int r = 0; r < 3; r++) for (int j = 0; j < 3; j++) m[r][j] = -(1 << 20);
    send_tile();
    check("sat_neg_s0", tile_0, {16'h8000, 48'd0});
    idle(2);

    // Backpressure: tile 1 held, tile 2 rows 0-2 overlap, row 3 stalls
    out_ready = 1'b0;
    rand_tile();
    send_tile();
    rand_tile();
    send_row(0); send_row(1); send_row(2);
    in_valid = 1'b1;
    row_in   = pack_row(3);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", {62'd0, in_ready_0, in_ready_2}, 64'd0);
      check("bp_valid_held", {62'd0, out_valid_0, out_valid_2}, 64'd3);
      check("bp_hold_s0", tile_0, exp0_q[0]);
      check("bp_hold_s2", tile_2, exp2_q[0]);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    #1 check("bp_in_ready_comb", {62'd0, in_ready_0, in_ready_2}, 64'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_expected();
    check("bp_tile2_valid", {62'd0, out_valid_0, out_valid_2}, 64'd3);
    check("bp_tile2_s0", tile_0, exp0_q[0]);
    idle(3);

    // clear with a pending tile and a same-cycle beat
    out_ready = 1'b0;
    rand_tile();
    send_tile();
    rand_tile();
    send_row(0); send_row(1);
    clear    = 1'b1;
    in_valid = 1'b1;
    row_in   = pack_row(2);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_keeps_valid", {62'd0, out_valid_0, out_valid_2}, 64'd3);
    check("clear_keeps_tile", tile_0, exp0_q[0]);
    out_ready = 1'b1;
    idle(1);
    set_all(1);
    send_tile();
    check("clear_ones_s0", tile_0, ONES_EXP);
    idle(2);

    // Asynchronous reset mid-tile with a pending output tile
    out_ready = 1'b0;
    rand_tile();
    send_tile();
    rand_tile();
    send_row(0); send_row(1); send_row(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {62'd0, out_valid_0, out_valid_2}, 64'd0);
    check("arst_tile", tile_0, 64'd0);
    exp0_q.delete();
    exp2_q.delete();
    load_flag = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    set_all(1);
    send_tile();
    check("arst_ones_s0", tile_0, ONES_EXP);
    idle(2);

    // Back-to-back random tiles: one tile per four clocks, no stalls
    stall_cnt = 0;
    for (int t = 0; t < 6; t++) begin
      rand_tile();
      send_tile();
    end
    check("stream_stalls", 64'(stall_cnt), 64'd0);

    // Drain and report
    waited = 0;
    while ((exp0_q.size() != 0 || exp2_q.size() != 0) && waited < 50) begin
      idle(1);
      waited++;
    end
    idle(2);
    check("q0_empty", 64'(exp0_q.size()), 64'd0);
    check("q2_empty", 64'(exp2_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
